pdk_sram_denetleyici: RTL

- Initiator-side controller for the single-port `pdk_sram` macro.
- Turns a valid/ready request channel from the core or cache into the macro's signals: CE strobe, active-low CSB/WEB/OEB, address and data.
- Captures read data on O and returns it on a valid/ready response channel.
- All macro-facing outputs are registered, so the CE pulse is glitch-free.

---
 rtl/pdk_sram_denetleyici.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pdk_sram_denetleyici.sv
// pdk_sram_denetleyici: valid/ready initiator for the single-port pdk_sram macro.
// Every macro-facing signal leaves a flop, so the CE strobe is glitch-free.
module pdk_sram_denetleyici #(
   parameter  int SATIR_SAYISI     = 64,
   parameter  int SOZCUK_GENISLIGI = 32,
   parameter  int BEKLEME_CEVRIMI  = 1,
   localparam int ADRES_GENISLIGI  = $clog2(SATIR_SAYISI)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        istek_gecerli_i,
   output logic                        istek_hazir_o,
   input  logic                        istek_yaz_i,
   input  logic [ADRES_GENISLIGI-1:0]  istek_adres_i,
   input  logic [SOZCUK_GENISLIGI-1:0] istek_veri_i,
   output logic                        yanit_gecerli_o,
   input  logic                        yanit_hazir_i,
   output logic [SOZCUK_GENISLIGI-1:0] yanit_veri_o,
   output logic                        yanit_hata_o,
   output logic                        sram_ce_o,
   output logic                        sram_web_o,
   output logic                        sram_oeb_o,
   output logic                        sram_csb_o,
   output logic [ADRES_GENISLIGI-1:0]  sram_a_o,
   output logic [SOZCUK_GENISLIGI-1:0] sram_i_o,
   input  logic [SOZCUK_GENISLIGI-1:0] sram_o_i
);

   typedef enum logic [2:0] {BOSTA, KURULUM, TETIK, OKU, YANIT} durum_t;

   // One extra bit keeps the range compare meaningful when SATIR_SAYISI is a power of 2.
   localparam logic [ADRES_GENISLIGI:0] SINIR             = SATIR_SAYISI[ADRES_GENISLIGI:0];
   localparam logic [3:0]               KURULUM_BASLANGIC = 4'(BEKLEME_CEVRIMI - 1);
   localparam logic [3:0]               OKU_BASLANGIC     = 4'd1;

   durum_t                      durum_q, durum_d;
   logic [3:0]                  sayac_q, sayac_d;
   logic                        yaz_q, yaz_d;
   logic                        ce_q, ce_d;
   logic                        web_q, web_d;
   logic                        oeb_q, oeb_d;
   logic                        csb_q, csb_d;
   logic [ADRES_GENISLIGI-1:0]  a_q, a_d;
   logic [SOZCUK_GENISLIGI-1:0] i_q, i_d;
   logic                        hazir_q, hazir_d;
   logic                        yg_q, yg_d;
   logic                        hata_q, hata_d;
   logic [SOZCUK_GENISLIGI-1:0] veri_q, veri_d;
   logic                        kabul;
   logic                        aralikta;

   assign kabul    = istek_gecerli_i & hazir_q;
   assign aralikta = {1'b0, istek_adres_i} < SINIR;

   // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
   always_comb begin
      durum_d = durum_q;
      sayac_d = sayac_q;
      yaz_d   = yaz_q;
      ce_d    = 1'b0;
      web_d   = web_q;
      oeb_d   = oeb_q;
      csb_d   = csb_q;
      a_d     = a_q;
      i_d     = i_q;
      hazir_d = hazir_q;
      yg_d    = yg_q;
      hata_d  = hata_q;
      veri_d  = veri_q;

      case (durum_q)
         BOSTA: begin
            hazir_d = 1'b1;
            if (kabul) begin
               hazir_d = 1'b0;
               yaz_d   = istek_yaz_i;
               if (aralikta) begin
                  a_d     = istek_adres_i;
                  i_d     = istek_veri_i;
                  web_d   = ~istek_yaz_i;
                  csb_d   = 1'b0;
                  sayac_d = KURULUM_BASLANGIC;
                  durum_d = KURULUM;
               end else if (istek_yaz_i) begin
                  // Dropped write: spend one cycle in TETIK with CE and CSB left inactive.
                  durum_d = TETIK;
               end else begin
                  veri_d  = '0;
                  hata_d  = 1'b1;
                  yg_d    = 1'b1;
                  durum_d = YANIT;
               end
            end
         end
         KURULUM: begin
            if (sayac_q == 4'd0) begin
               ce_d    = 1'b1;
               durum_d = TETIK;
            end else begin
               sayac_d = sayac_q - 4'd1;
            end
         end
         TETIK: begin
            if (yaz_q) begin
               csb_d   = 1'b1;
               web_d   = 1'b1;
               hazir_d = 1'b1;
               durum_d = BOSTA;
            end else begin
               oeb_d   = 1'b0;
               sayac_d = OKU_BASLANGIC;
               durum_d = OKU;
            end
         end
         OKU: begin
            // OEB is registered, so O only drives from OKU entry; allow it a cycle to settle.
            if (sayac_q == 4'd0) begin
               veri_d  = sram_o_i;
               hata_d  = 1'b0;
               oeb_d   = 1'b1;
               csb_d   = 1'b1;
               yg_d    = 1'b1;
               durum_d = YANIT;
            end else begin
               sayac_d = sayac_q - 4'd1;
            end
         end
         YANIT: begin
            if (yanit_hazir_i) begin
               yg_d    = 1'b0;
               hazir_d = 1'b1;
               durum_d = BOSTA;
            end
         end
         default: durum_d = BOSTA;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the async reset aborts any access.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         durum_q <= BOSTA;
         sayac_q <= 4'd0;
         yaz_q   <= 1'b0;
         ce_q    <= 1'b0;
         web_q   <= 1'b1;
         oeb_q   <= 1'b1;
         csb_q   <= 1'b1;
         a_q     <= '0;
         i_q     <= '0;
         hazir_q <= 1'b0;
         yg_q    <= 1'b0;
         hata_q  <= 1'b0;
         veri_q  <= '0;
      end else begin
         durum_q <= durum_d;
         sayac_q <= sayac_d;
         yaz_q   <= yaz_d;
         ce_q    <= ce_d;
         web_q   <= web_d;
         oeb_q   <= oeb_d;
         csb_q   <= csb_d;
         a_q     <= a_d;
         i_q     <= i_d;
         hazir_q <= hazir_d;
         yg_q    <= yg_d;
         hata_q  <= hata_d;
         veri_q  <= veri_d;
      end
   end

   assign istek_hazir_o   = hazir_q;
   assign yanit_gecerli_o = yg_q;
   assign yanit_veri_o    = veri_q;
   assign yanit_hata_o    = hata_q;
   assign sram_ce_o       = ce_q;
   assign sram_web_o      = web_q;
   assign sram_oeb_o      = oeb_q;
   assign sram_csb_o      = csb_q;
   assign sram_a_o        = a_q;
   assign sram_i_o        = i_q;

endmodule
